// File: rtl/demux1to8_reg.sv
// Registered 1-to-8 demultiplexer with eight single-entry holding registers,
// each drained over its own valid/ready handshake; optional round-robin select.
module demux1to8_reg #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               C2,
    input  logic               C1,
    input  logic               C0,
    input  logic               auto_sel,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic [8*WIDTH-1:0] out_data,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready,
    output logic [2:0]         ptr,
    output logic [3:0]         pending
);

    logic [7:0][WIDTH-1:0] data_q, data_d;
    logic [7:0]            valid_q, valid_d;
    logic [2:0]            ptr_q, ptr_d;
    logic [3:0]            pending_q, pending_d;

    logic [2:0] sel;
    logic       accept;

    always_comb begin
        sel      = auto_sel ? ptr_q : {C2, C1, C0};
        // A draining slot counts as free so it can be refilled without a bubble.
        in_ready = ~valid_q[sel] | out_ready[sel];
        accept   = in_valid & in_ready;
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q & ~out_ready;
        ptr_d     = ptr_q;
        pending_d = '0;
        if (accept) begin
            data_d[sel]  = in_data;
            valid_d[sel] = 1'b1;
            if (auto_sel) begin
                ptr_d = ptr_q + 3'd1;
            end
        end
        for (int k = 0; k < 8; k++) begin
            pending_d = pending_d + {3'b000, valid_d[k]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= '0;
            ptr_q     <= '0;
            pending_q <= '0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign ptr       = ptr_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_demux1to8_reg.sv
// Bench for demux1to8_reg: directed scenarios plus random traffic, all checked
// against an array-based reference model of the eight holding slots.
module tb_demux1to8_reg;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           c2 = 1'b0, c1 = 1'b0, c0 = 1'b0;
    logic           auto_sel = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           in_ready;
    logic [8*W-1:0] out_data;
    logic [7:0]     out_valid;
    logic [7:0]     out_ready = '0;
    logic [2:0]     ptr;
    logic [3:0]     pending;

    demux1to8_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .C2(c2), .C1(c1), .C0(c0),
        .auto_sel(auto_sel), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .ptr(ptr), .pending(pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] md [8];
    bit           mv [8];
    int           mptr;

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            md[k] = '0;
            mv[k] = 1'b0;
        end
        mptr = 0;
    endtask

    function automatic int sel_now();
        return auto_sel ? mptr : int'({c2, c1, c0});
    endfunction

    function automatic logic [7:0] exp_valid();
        logic [7:0] r = '0;
        for (int k = 0; k < 8; k++) r[k] = mv[k];
        return r;
    endfunction

    function automatic logic [8*W-1:0] exp_data();
        logic [8*W-1:0] r = '0;
        for (int k = 0; k < 8; k++) r[k*W +: W] = md[k];
        return r;
    endfunction

    function automatic int exp_pending();
        int n = 0;
        for (int k = 0; k < 8; k++) if (mv[k]) n++;
        return n;
    endfunction

    function automatic logic exp_ready();
        int s = sel_now();
        return !mv[s] || out_ready[s];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(exp_ready()));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid()));
        chk({tag, ".out_data"},  32'(out_data),  32'(exp_data()));
        chk({tag, ".ptr"},       32'(ptr),       32'(mptr));
        chk({tag, ".pending"},   32'(pending),   32'(exp_pending()));
    endtask

    // Advance one clock; the model applies the same accept/drain rules the
    // inputs imply, then every output is compared.
    task automatic tick(input string tag);
        int s;
        bit acc;
        s   = sel_now();
        acc = in_valid && (!mv[s] || out_ready[s]);
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) if (mv[k] && out_ready[k]) mv[k] = 1'b0;
        if (acc) begin
            md[s] = in_data;
            mv[s] = 1'b1;
            if (auto_sel) mptr = (mptr + 1) % 8;
        end
        check_all(tag);
    endtask

    task automatic set_sel(input logic [2:0] v);
        {c2, c1, c0} = v;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", 32'(out_valid), 32'h0);
        chk("reset.pending",   32'(pending),   32'h0);
        chk("reset.ptr",       32'(ptr),       32'h0);
        chk("reset.out_data",  32'(out_data),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single manual write to channel 5
        set_sel(3'b101); in_valid = 1; in_data = 4'hA;
        tick("wr5");
        chk("wr5.valid", 32'(out_valid), 32'h20);
        chk("wr5.data",  32'(out_data[23:20]), 32'hA);
        chk("wr5.pend",  32'(pending), 32'd1);
        chk("wr5.ptr",   32'(ptr), 32'd0);

        // Stall on full channel 5, then drain-and-refill in one cycle
        in_data = 4'h3; out_ready = '0;
        #1 chk("stall.in_ready", 32'(in_ready), 32'd0);
        tick("stall");
        chk("stall.data", 32'(out_data[23:20]), 32'hA);
        out_ready = 8'h20;
        #1 chk("refill.in_ready", 32'(in_ready), 32'd1);
        tick("refill");
        chk("refill.data",  32'(out_data[23:20]), 32'h3);
        chk("refill.valid", 32'(out_valid[5]), 32'd1);
        chk("refill.pend",  32'(pending), 32'd1);

        in_valid = 0; out_ready = 8'hFF;
        tick("drain_all");

        // Auto-mode burst fills all eight lanes in order
        auto_sel = 1; out_ready = '0; in_valid = 1;
        for (int k = 0; k < 8; k++) begin
            in_data = W'(k);
            tick("burst");
        end
        chk("burst.data",  32'(out_data), 32'h76543210);
        chk("burst.valid", 32'(out_valid), 32'hFF);
        chk("burst.pend",  32'(pending), 32'd8);
        chk("burst.ptr",   32'(ptr), 32'd0);
        in_data = 4'h9;
        #1 chk("ninth.in_ready", 32'(in_ready), 32'd0);
        tick("ninth");

        // Refill of draining channel 0 keeps occupancy at 8
        out_ready = 8'h01; in_data = 4'h8;
        #1 chk("ch0.in_ready", 32'(in_ready), 32'd1);
        tick("ch0");
        chk("ch0.data",  32'(out_data[3:0]), 32'h8);
        chk("ch0.valid", 32'(out_valid), 32'hFF);
        chk("ch0.pend",  32'(pending), 32'd8);
        chk("ch0.ptr",   32'(ptr), 32'd1);

        // Free channel 6, then drain 2 while writing 6
        in_valid = 0; out_ready = 8'h40;
        tick("free6");
        auto_sel = 0; set_sel(3'd6); in_valid = 1; in_data = 4'h9; out_ready = 8'h04;
        tick("swap");
        chk("swap.v2",   32'(out_valid[2]), 32'd0);
        chk("swap.v6",   32'(out_valid[6]), 32'd1);
        chk("swap.pend", 32'(pending), 32'd7);

        in_valid = 0; out_ready = '0;
        auto_sel = 1; tick("tog1");
        auto_sel = 0; tick("tog0");
        auto_sel = 1; tick("tog1b");
        chk("toggle.ptr", 32'(ptr), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            auto_sel  = ($urandom_range(0, 3) != 0);
            set_sel(3'($urandom_range(0, 7)));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            out_ready = 8'($urandom) & 8'($urandom);
            tick("rand");
        end

        // Fill all lanes, then asynchronous reset between edges
        in_valid = 0; out_ready = 8'hFF;
        tick("predrain");
        out_ready = '0; auto_sel = 0; in_valid = 1;
        for (int k = 0; k < 8; k++) begin
            set_sel(3'(k));
            in_data = W'(15 - k);
            tick("fill");
        end
        chk("fill.valid", 32'(out_valid), 32'hFF);
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("arst.out_valid", 32'(out_valid), 32'h0);
        chk("arst.pending",   32'(pending),   32'h0);
        chk("arst.ptr",       32'(ptr),       32'h0);
        chk("arst.out_data",  32'(out_data),  32'h0);
        #2 rst_n = 1;
        @(posedge clk);
        #1;
        set_sel(3'd0); in_valid = 1; in_data = 4'h5;
        tick("post");
        chk("post.valid", 32'(out_valid), 32'h01);
        chk("post.data",  32'(out_data[3:0]), 32'h5);
        chk("post.pend",  32'(pending), 32'd1);
        in_valid = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux1to8_reg.md
Name: demux1to8_reg

Overview:
- Registered 1-to-8 demultiplexer: the distribution end of the 8-to-1 select path.
- Takes one WIDTH-bit input stream with a 3-bit channel select {C2,C1,C0}. Steers each accepted word into one of eight single-entry holding registers.
- Each register drains to its own consumer over a valid/ready handshake.
- An optional auto mode replaces the external select with an internal round-robin pointer. This lets the block act as a sequential deserializer feeding the 8-lane datapath.

Parameters:
WIDTH, 4, data width of input word and of each output channel

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
C2  input  1  channel select MSB (manual mode)
C1  input  1  channel select bit 1
C0  input  1  channel select LSB
auto_sel  input  1  1 = use internal pointer as select, 0 = use {C2,C1,C0}
in_valid  input  1  input word present
in_data  input  WIDTH  input word
in_ready  output  1  block can accept in_data this cycle
out_data  output  8*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
out_valid  output  8  channel k holds an undelivered word
out_ready  input  8  consumer k takes its word this cycle
ptr  output  3  current round-robin pointer
pending  output  4  number of channels with out_valid set, 0..8

Behaviour:
- Reset (rst_n low, asynchronous) sets all out_valid to 0, all out_data to 0, ptr to 0 and pending to 0. Any data held at reset is discarded.
- Effective select: s = auto_sel ? ptr : {C2,C1,C0}. It is evaluated combinationally every cycle; there is no latching of the select.
- in_ready = ~out_valid[s] | out_ready[s]. A full slot being drained in the same cycle may be refilled with no bubble.
- in_ready is combinational from the select, auto_sel, ptr, out_valid and out_ready only, never from in_valid.
- Accept when in_valid & in_ready at the rising edge:
  - out_data[s] <= in_data and out_valid[s] <= 1.
  - Latency is 1 cycle from accept to out_valid.
- Channel k drain: when out_valid[k] & out_ready[k], out_valid[k] <= 0, unless channel k is written in the same cycle, in which case it stays 1 with the new data.
- out_ready[k] while out_valid[k] = 0 has no effect.
- out_data[k] holds its last written value after drain. It is only meaningful while out_valid[k] = 1.
- Unselected channels are never modified by an accept.
- in_valid with in_ready = 0 changes no state, and the word is not consumed. The producer must hold it.
- In manual mode the producer may change the select or data while stalled; the new select is used on the next cycle.
- ptr:
  - Increments by 1 mod 8 on each accept while auto_sel = 1, wrapping 7 -> 0.
  - Holds when no accept occurs or when auto_sel = 0.
  - Toggling auto_sel preserves ptr.
- pending is registered and equals the popcount of out_valid after each edge. In the same cycle:
  - one fill of an empty channel plus one drain of another gives a net change of 0;
  - a refill of the draining channel also gives a net change of 0.
- Throughput: one word per cycle whenever the target channel is empty or draining.

Test Plan:
- Reset, then manual select 3'b101, in_valid = 1, in_data = 4'hA for one cycle -> next cycle out_valid = 8'b0010_0000, out_data[23:20] = 4'hA, pending = 1, ptr = 0.
- Channel 5 full with out_ready[5] = 0, second word 4'h3 to select 5 -> in_ready = 0, out_data[23:20] stays 4'hA. Then assert out_ready[5] with 4'h3 still presented -> in_ready = 1, next cycle channel 5 = 4'h3, out_valid[5] = 1, pending = 1.
- auto_sel = 1, all out_ready = 0, stream 4'h0..4'h7 back-to-back -> channel k holds value k, out_valid = 8'hFF, pending = 8, ptr wraps to 0. A ninth word gives in_ready = 0.
- Continuation of the previous case: hold out_ready[0] = 1 only and present 4'h8 in auto mode -> channel 0 = 4'h8, out_valid stays 8'hFF, pending stays 8, ptr = 1.
- Same-cycle drain of channel 2 and write of channel 6 -> out_valid[2] = 0, out_valid[6] = 1, pending unchanged. Toggle auto_sel 1 -> 0 -> 1 -> ptr unchanged.
- Reset mid-operation: assert rst_n = 0 asynchronously between edges with out_valid = 8'hFF -> out_valid = 0, pending = 0, ptr = 0 immediately, out_data = 0. After release, the first accept to select 0 works normally.
